// File: rtl/decode_pkg.sv
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared constants and helper functions for the RISC-V decode
//                stage: major opcodes, immediate-type encodings, immediate
//                extraction and (optional) illegal-encoding classification.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Immediate-type encodings presented on out_imm_t
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Immediate format selected purely by major opcode; unknown opcodes carry no immediate
    function automatic logic [2:0] imm_type(input logic [6:0] opc);
        logic [2:0] t;
        t = IMM_NONE;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_OP_IMM_32: t = IMM_I;
            OPC_STORE:                                                 t = IMM_S;
            OPC_BRANCH:                                                t = IMM_B;
            OPC_JAL:                                                   t = IMM_J;
            OPC_LUI, OPC_AUIPC:                                        t = IMM_U;
            default:                                                   t = IMM_NONE;
        endcase
        return t;
    endfunction

    // 32-bit sign-extended immediate; widened to XLEN by the caller using bit 31
    function automatic logic [31:0] imm32(input logic [31:0] instr, input logic [2:0] t);
        logic [31:0] v;
        v = 32'd0;
        case (t)
            IMM_I: v = {{20{instr[31]}}, instr[31:20]};
            IMM_S: v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: v = {instr[31:12], 12'd0};
            IMM_J: v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Encoding legality: compressed/unknown opcodes, RV64-only opcodes on RV32,
    // and reserved funct3 values of BRANCH/LOAD/STORE
    function automatic logic illegal_instr(input logic [31:0] instr, input logic rv64);
        logic [2:0] f3;
        logic       bad;
        f3  = instr[14:12];
        bad = (instr[1:0] != 2'b11);
        case (instr[6:0])
            OPC_LOAD: begin
                if (f3 == 3'b111 || (!rv64 && (f3 == 3'b011 || f3 == 3'b110)))
                    bad = 1'b1;
            end
            OPC_STORE: begin
                if (f3[2] || (!rv64 && f3 == 3'b011))
                    bad = 1'b1;
            end
            OPC_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011)
                    bad = 1'b1;
            end
            OPC_OP_IMM_32, OPC_OP_32: begin
                if (!rv64)
                    bad = 1'b1;
            end
            OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP, OPC_LUI,
            OPC_JALR, OPC_JAL, OPC_SYSTEM: begin
                bad = bad;
            end
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_queue.sv
// ============================================================================
//  Module      : instr_queue
//  Description : Synchronous FIFO holding {pc,instr} words ahead of decode.
//                Push/pop may coincide; flush empties it in one cycle.
//                Caller guarantees no push when full and no pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   wdata,
    output logic [W-1:0]                   rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);

    logic [W-1:0]      r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;

    // Storage write; contents need no reset since count qualifies them
    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= wdata;
    end

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (pop)
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            if (push && !pop)
                r_count <= r_count + c_cw'(1);
            else if (pop && !push)
                r_count <= r_count - c_cw'(1);
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
//  Module      : decode_stage
//  Description : RISC-V decode stage. Queues fetched {pc,instr} pairs, decodes
//                the queue head combinationally and registers the bundle for
//                execute behind a valid/ready handshake. Flush clears all.
//  Options     : DECODE_ILLEGAL_EN - enables illegal-encoding detection on
//                out_illegal; when undefined out_illegal is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [6:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [XLEN-1:0]   out_imm,
    output logic [2:0]        out_imm_t,
    output logic              out_illegal
);

    localparam int c_qw    = PC_W + 32;
    localparam int c_cnt_w = $clog2(QDEPTH + 1);

    logic [c_qw-1:0]     w_head;
    logic [c_cnt_w-1:0]  w_count;
    logic [PC_W-1:0]     w_pc;
    logic [31:0]         w_instr;
    logic [2:0]          w_imm_t;
    logic [31:0]         w_imm32;
    logic [XLEN-1:0]     w_imm;
    logic                w_in_ready;
    logic                w_push;
    logic                w_load;

    logic                r_valid;
    logic [PC_W-1:0]     r_pc;
    logic [6:0]          r_opcode;
    logic [4:0]          r_rd;
    logic [4:0]          r_rs1;
    logic [4:0]          r_rs2;
    logic [2:0]          r_funct3;
    logic [6:0]          r_funct7;
    logic [XLEN-1:0]     r_imm;
    logic [2:0]          r_imm_t;

    // Handshake control: a full queue refuses input even while it is being popped,
    // and flush suppresses both push and load in the same cycle
    assign w_in_ready = !rst && (w_count != c_cnt_w'(QDEPTH));
    assign w_push     = in_valid && w_in_ready && !flush;
    assign w_load     = (w_count != '0) && (!r_valid || out_ready) && !flush;

    instr_queue #(
        .W     (c_qw),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_load),
        .wdata ({in_pc, in_instr}),
        .rdata (w_head),
        .count (w_count)
    );

    assign w_pc    = w_head[c_qw-1:32];
    assign w_instr = w_head[31:0];
    assign w_imm_t = imm_type(w_instr[6:0]);
    assign w_imm32 = imm32(w_instr, w_imm_t);

    generate
        if (XLEN > 32) begin : g_imm_sext
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_direct
            assign w_imm = w_imm32;
        end
    endgenerate

    // Output bundle register: load head when free or consumed, otherwise drop valid once taken
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_opcode <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_funct3 <= '0;
            r_funct7 <= '0;
            r_imm    <= '0;
            r_imm_t  <= IMM_NONE;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_pc     <= w_pc;
            r_opcode <= w_instr[6:0];
            r_rd     <= w_instr[11:7];
            r_rs1    <= w_instr[19:15];
            r_rs2    <= w_instr[24:20];
            r_funct3 <= w_instr[14:12];
            r_funct7 <= w_instr[31:25];
            r_imm    <= w_imm;
            r_imm_t  <= w_imm_t;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    localparam logic c_rv64 = (XLEN == 64);
    logic w_illegal;
    logic r_illegal;

    assign w_illegal = illegal_instr(w_instr, c_rv64);

    // Illegal flag travels with the rest of the bundle
    always_ff @(posedge clk) begin
        if (rst || flush)
            r_illegal <= 1'b0;
        else if (w_load)
            r_illegal <= w_illegal;
    end

    assign out_illegal = r_illegal;
`else
    assign out_illegal = 1'b0;
`endif

    assign in_ready   = w_in_ready;
    assign out_valid  = r_valid;
    assign out_pc     = r_pc;
    assign out_opcode = r_opcode;
    assign out_rd     = r_rd;
    assign out_rs1    = r_rs1;
    assign out_rs2    = r_rs2;
    assign out_funct3 = r_funct3;
    assign out_funct7 = r_funct7;
    assign out_imm    = r_imm;
    assign out_imm_t  = r_imm_t;

endmodule

`default_nettype wire
